// File: rtl/snes_button_events.sv
// SNES button vector to press/release event queue: synchronize, debounce the whole vector,
// scan changed bits in index order and buffer one event per changed button in a small FIFO.
module snes_button_events #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned DEPTH_LOG2      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            buttons,
    output logic [5:0]            stable_buttons,
    output logic                  evt_valid,
    output logic [3:0]            evt_data,
    input  logic                  evt_rd,
    output logic [DEPTH_LOG2:0]   evt_count,
    output logic                  busy
);

    localparam logic [15:0]         CNT_MAX  = 16'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {StIdle, StScan} state_t;

    logic [5:0]            r_sync1;
    logic [5:0]            r_sync2;
    logic [5:0]            r_cand;
    logic [15:0]           r_cnt;
    logic [5:0]            r_stable;
    logic [5:0]            r_mask;
    logic [2:0]            r_idx;
    state_t                r_state;
    logic [3:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic       w_full;
    logic       w_empty;
    logic       w_bit;
    logic       w_push;
    logic       w_pop;
    logic       w_commit;
    logic [3:0] w_push_data;

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_bit       = r_mask[r_idx];
    assign w_push      = (r_state == StScan) && w_bit && !w_full;
    assign w_pop       = evt_rd && !w_empty;
    assign w_commit    = (r_state == StIdle) && (r_cnt == CNT_MAX) && (r_cand != r_stable);
    assign w_push_data = {r_stable[r_idx], r_idx};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Commits are held off while scanning; later changes fold into the next commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_stable <= '0;
            r_mask   <= '0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_commit) begin
                        r_mask   <= r_cand ^ r_stable;
                        r_stable <= r_cand;
                        r_idx    <= '0;
                        r_state  <= StScan;
                    end
                end
                StScan: begin
                    if (!w_bit || !w_full) begin
                        if (r_idx == 3'd5) begin
                            r_state <= StIdle;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign stable_buttons = r_stable;
    assign evt_valid      = !w_empty;
    assign evt_data       = w_empty ? 4'd0 : r_mem[r_rd_ptr];
    assign evt_count      = r_count;
    assign busy           = (r_state == StScan);

endmodule
